// File: rtl/out_fm_fifo_to_wmst_tile_if.sv
// Bus bundle between the out-FM tile store adapter, the out-FM FIFO and the
// Avalon write master. The adapter takes the master modport.
interface out_fm_fifo_to_wmst_tile_if #(
    parameter int CW  = 16,
    parameter int DW  = 32,
    parameter int XAW = 32,
    parameter int XDW = 128
);
    // out-FM FIFO side
    logic           store_fifo_pop;
    logic [DW-1:0]  store_fifo_data;
    logic           store_fifo_empty;

    // write-master side
    logic           wmst_fixed_location;
    logic [XAW-1:0] wmst_write_base;
    logic [CW-1:0]  wmst_write_length;
    logic           wmst_go;
    logic           wmst_done;
    logic           wmst_user_write_buffer;
    logic [XDW-1:0] wmst_user_buffer_data;
    logic           wmst_user_buffer_full;

    modport master (
        output store_fifo_pop,
        input  store_fifo_data,
        input  store_fifo_empty,
        output wmst_fixed_location,
        output wmst_write_base,
        output wmst_write_length,
        output wmst_go,
        input  wmst_done,
        output wmst_user_write_buffer,
        output wmst_user_buffer_data,
        input  wmst_user_buffer_full
    );

    modport slave (
        input  store_fifo_pop,
        output store_fifo_data,
        output store_fifo_empty,
        input  wmst_fixed_location,
        input  wmst_write_base,
        input  wmst_write_length,
        input  wmst_go,
        output wmst_done,
        input  wmst_user_write_buffer,
        input  wmst_user_buffer_data,
        output wmst_user_buffer_full
    );
endinterface

// File: rtl/out_fm_fifo_to_wmst_tile.sv
// Out-FM tile store adapter: drains one output tile from the out-FM FIFO,
// packs 32-bit words into XDW-bit beats and issues one write-master
// transaction per tile row (channel-major, then row).
module out_fm_fifo_to_wmst_tile #(
    parameter int AW   = 12,
    parameter int CW   = 16,
    parameter int DW   = 32,
    parameter int XAW  = 32,
    parameter int XDW  = 128,
    parameter int M    = 32,
    parameter int R    = 64,
    parameter int C    = 32,
    parameter int Tm   = 16,
    parameter int Tr   = 64,
    parameter int Tc   = 16,
    parameter int WCNT = XDW / DW
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          store_start,
    output logic                          store_done,
    input  logic [XAW-1:0]                store_base_addr,
    input  logic [CW-1:0]                 tile_base_m,
    input  logic [CW-1:0]                 tile_base_row,
    input  logic [CW-1:0]                 tile_base_col,
    out_fm_fifo_to_wmst_tile_if.master    bus
);
    localparam int BEATS = Tc / WCNT;
    localparam int IW    = (WCNT > 1) ? $clog2(WCNT) : 1;
    localparam int PW    = $clog2(WCNT + 1);

    localparam logic [XAW-1:0] ROW_STRIDE = XAW'(C * 4);
    localparam logic [XAW-1:0] CH_STRIDE  = XAW'(R * C * 4);
    localparam logic [CW-1:0]  ROW_BYTES  = CW'(Tc * 4);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_GO, S_FILL, S_WAIT_DONE, S_NEXT, S_DONE
    } state_t;

    state_t                  state;
    logic [CW-1:0]           org_m, org_row, org_col;
    logic [CW-1:0]           rows_v, ch_v, r_cnt, c_cnt;
    logic [XAW-1:0]          row_addr, ch_addr;
    logic [AW-1:0]           row_pops, beat_cnt;
    logic [PW-1:0]           pack_cnt;
    logic                    pop_inflight, seen_busy, done_q;
    logic [CW-1:0]           length_q;
    logic [WCNT-1:0][DW-1:0] pack_data;

    // Clipped tile extent at the right/bottom edge of the feature map.
    logic [CW:0]    rows_left, ch_left;
    logic [CW-1:0]  rows_clip, ch_clip;
    logic [XAW-1:0] org_offset;
    logic [PW:0]    pending;
    logic           pop, push;

    assign rows_left  = (CW+1)'(R) - {1'b0, org_row};
    assign ch_left    = (CW+1)'(M) - {1'b0, org_m};
    assign rows_clip  = (rows_left < (CW+1)'(Tr)) ? rows_left[CW-1:0] : CW'(Tr);
    assign ch_clip    = (ch_left   < (CW+1)'(Tm)) ? ch_left[CW-1:0]   : CW'(Tm);
    assign org_offset = ((XAW'(org_m) * XAW'(R) + XAW'(org_row)) * XAW'(C)
                         + XAW'(org_col)) << 2;

    // Words already packed plus the one whose data arrives this cycle.
    assign pending = {1'b0, pack_cnt} + (PW+1)'(pop_inflight);
    assign pop  = (state == S_FILL) && !bus.store_fifo_empty
               && (row_pops < AW'(Tc)) && (pending < (PW+1)'(WCNT));
    assign push = (state == S_FILL) && (pack_cnt == PW'(WCNT))
               && !bus.wmst_user_buffer_full;

    assign bus.store_fifo_pop         = pop;
    assign bus.wmst_user_write_buffer = push;
    assign bus.wmst_user_buffer_data  = pack_data;
    assign bus.wmst_go                = (state == S_GO) && bus.wmst_done;
    assign bus.wmst_write_base        = row_addr;
    assign bus.wmst_write_length      = length_q;
    assign bus.wmst_fixed_location    = 1'b0;
    assign store_done                 = done_q;

    // Tile sequencer, FIFO drain and beat packing.
    // NOTE: every register here uses <=, so all reads within one edge see the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            org_m        <= '0;
            org_row      <= '0;
            org_col      <= '0;
            rows_v       <= '0;
            ch_v         <= '0;
            r_cnt        <= '0;
            c_cnt        <= '0;
            row_addr     <= '0;
            ch_addr      <= '0;
            row_pops     <= '0;
            beat_cnt     <= '0;
            pack_cnt     <= '0;
            pop_inflight <= 1'b0;
            seen_busy    <= 1'b0;
            done_q       <= 1'b0;
            length_q     <= '0;
            // NOTE: the pack register drives the beat bus directly, so it is
            // cleared on reset to keep that output at zero.
            pack_data    <= '0;
        end else begin
            done_q       <= 1'b0;
            pop_inflight <= pop;
            if (pop) row_pops <= row_pops + AW'(1);
            if (pop_inflight) begin
                pack_data[pack_cnt[IW-1:0]] <= bus.store_fifo_data;
                pack_cnt                    <= pack_cnt + PW'(1);
            end

            case (state)
                S_IDLE: begin
                    if (store_start) begin
                        org_m   <= tile_base_m;
                        org_row <= tile_base_row;
                        org_col <= tile_base_col;
                        state   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    row_addr <= store_base_addr + org_offset;
                    ch_addr  <= store_base_addr + org_offset;
                    rows_v   <= rows_clip;
                    ch_v     <= ch_clip;
                    r_cnt    <= '0;
                    c_cnt    <= '0;
                    length_q <= ROW_BYTES;
                    state    <= S_GO;
                end
                S_GO: begin
                    if (bus.wmst_done) begin
                        seen_busy <= 1'b0;
                        row_pops  <= '0;
                        beat_cnt  <= '0;
                        pack_cnt  <= '0;
                        state     <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (!bus.wmst_done) seen_busy <= 1'b1;
                    if (push) begin
                        pack_cnt <= '0;
                        beat_cnt <= beat_cnt + AW'(1);
                        if (beat_cnt == AW'(BEATS - 1)) state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!bus.wmst_done) seen_busy <= 1'b1;
                    else if (seen_busy) state <= S_NEXT;
                end
                S_NEXT: begin
                    if (r_cnt + CW'(1) < rows_v) begin
                        r_cnt    <= r_cnt + CW'(1);
                        row_addr <= row_addr + ROW_STRIDE;
                        state    <= S_GO;
                    end else if (c_cnt + CW'(1) < ch_v) begin
                        c_cnt    <= c_cnt + CW'(1);
                        r_cnt    <= '0;
                        ch_addr  <= ch_addr + CH_STRIDE;
                        row_addr <= ch_addr + CH_STRIDE;
                        state    <= S_GO;
                    end else begin
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_out_fm_fifo_to_wmst_tile.sv
// Self-checking bench for out_fm_fifo_to_wmst_tile with a small FIFO model
// and a write-master model; table-driven tile scenarios plus reset sequences.
module tb_out_fm_fifo_to_wmst_tile;
    localparam int M = 2, R = 4, C = 8, TM = 2, TR = 2, TC = 8, WCNT = 4;
    localparam int BEATS = TC / WCNT;
    localparam int FIFO_WORDS = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        store_start;
    logic        store_done;
    logic [31:0] store_base_addr;
    logic [15:0] tile_base_m, tile_base_row, tile_base_col;
    logic        full;
    bit          stall_en;

    out_fm_fifo_to_wmst_tile_if #(.CW(16), .DW(32), .XAW(32), .XDW(128)) bus ();

    out_fm_fifo_to_wmst_tile #(
        .AW(12), .CW(16), .DW(32), .XAW(32), .XDW(128),
        .M(M), .R(R), .C(C), .Tm(TM), .Tr(TR), .Tc(TC), .WCNT(WCNT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .store_start(store_start),
        .store_done(store_done),
        .store_base_addr(store_base_addr),
        .tile_base_m(tile_base_m),
        .tile_base_row(tile_base_row),
        .tile_base_col(tile_base_col),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    // FIFO model: word value equals its index; data valid the cycle after pop.
    int          fifo_rd, stall_hold, viol_pop_empty;
    logic [31:0] fifo_q;
    assign bus.store_fifo_empty = (fifo_rd >= FIFO_WORDS)
                               || (stall_en && fifo_rd == 3 && stall_hold < 5);
    assign bus.store_fifo_data  = fifo_q;
    always @(posedge clk) begin
        if (rst) begin
            fifo_rd <= 0; stall_hold <= 0; fifo_q <= '0; viol_pop_empty <= 0;
        end else begin
            if (bus.store_fifo_pop) begin
                if (bus.store_fifo_empty) viol_pop_empty <= viol_pop_empty + 1;
                fifo_rd <= fifo_rd + 1;
                fifo_q  <= 32'(fifo_rd);
            end
            if (stall_en && fifo_rd == 3 && stall_hold < 5) stall_hold <= stall_hold + 1;
        end
    end

    // Write-master model: busy from go until all beats arrive plus 3 cycles.
    logic wdone;
    int   left, tail;
    assign bus.wmst_done             = wdone;
    assign bus.wmst_user_buffer_full = full;
    always @(posedge clk) begin
        if (rst) begin
            wdone <= 1'b1; left <= 0; tail <= 0;
        end else if (bus.wmst_go) begin
            wdone <= 1'b0; left <= BEATS; tail <= 0;
        end else if (!wdone) begin
            if (left != 0) begin
                if (bus.wmst_user_write_buffer) left <= left - 1;
            end else if (tail == 2) wdone <= 1'b1;
            else tail <= tail + 1;
        end
    end

    // Monitor, sampled on the falling edge.
    int           cyc, n_go, n_push, n_pop, n_done, viol_unstable, viol_full_push;
    int           start_cyc, first_go_cyc, last_exit_cyc, done_cyc, beats_tx[8];
    bit           start_seen, in_tx, seen_low;
    logic [31:0]  go_base[8], cur_base;
    logic [15:0]  go_len[8], cur_len;
    logic [127:0] beats_q[$];
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            n_go <= 0; n_push <= 0; n_pop <= 0; n_done <= 0;
            viol_unstable <= 0; viol_full_push <= 0; in_tx <= 1'b0;
            start_seen <= 1'b0; start_cyc <= 0; first_go_cyc <= 0;
            last_exit_cyc <= 0; done_cyc <= 0;
            for (int i = 0; i < 8; i++) begin
                beats_tx[i] <= 0; go_base[i] <= '0; go_len[i] <= '0;
            end
            beats_q.delete();
        end else begin
            if (store_start && !start_seen) begin
                start_seen <= 1'b1; start_cyc <= cyc;
            end
            if (bus.wmst_go) begin
                if (n_go < 8) begin
                    go_base[n_go] <= bus.wmst_write_base;
                    go_len[n_go]  <= bus.wmst_write_length;
                end
                if (n_go == 0) first_go_cyc <= cyc;
                n_go <= n_go + 1; in_tx <= 1'b1; seen_low <= 1'b0;
                cur_base <= bus.wmst_write_base; cur_len <= bus.wmst_write_length;
            end else if (in_tx) begin
                if (bus.wmst_write_base !== cur_base || bus.wmst_write_length !== cur_len)
                    viol_unstable <= viol_unstable + 1;
                if (!wdone) seen_low <= 1'b1;
                else if (seen_low) begin
                    in_tx <= 1'b0; last_exit_cyc <= cyc;
                end
            end
            if (bus.wmst_user_write_buffer) begin
                if (full) viol_full_push <= viol_full_push + 1;
                n_push <= n_push + 1;
                beats_q.push_back(bus.wmst_user_buffer_data);
                if (n_go > 0 && n_go <= 8) beats_tx[n_go-1] <= beats_tx[n_go-1] + 1;
            end
            if (bus.store_fifo_pop) n_pop <= n_pop + 1;
            if (store_done) begin
                n_done <= n_done + 1; done_cyc <= cyc;
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic wait_go(input int target);
        int k = 0;
        while (n_go < target && k < 500) begin
            step(1); k++;
        end
        check("wait_go", 128'(n_go >= target), 128'd1);
    endtask

    typedef struct {
        logic [15:0]      row;
        logic [31:0]      base;
        int               n_tx;
        logic [3:0][31:0] addr;
        int               n_pops;
        int               n_beats;
        bit               full_stall;
        bit               empty_stall;
        bit               restart;
    } vec_t;

    vec_t vecs[6];

    task automatic run_case(input vec_t v, input bit with_reset, input string tag);
        int p0, s0, k;
        logic [127:0] e;
        if (with_reset) do_reset();
        stall_en        = v.empty_stall;
        full            = v.full_stall;
        store_base_addr = v.base;
        tile_base_m     = '0;
        tile_base_row   = v.row;
        tile_base_col   = '0;
        store_start = 1'b1;
        step(1);
        store_start = 1'b0;
        if (v.full_stall) begin
            wait_go(1);
            p0 = n_pop; s0 = n_push;
            step(16);
            check({tag, ".stall_pops"}, 128'(n_pop - p0), 128'd4);
            check({tag, ".stall_push"}, 128'(n_push - s0), 128'd0);
            full = 1'b0;
        end
        if (v.restart) begin
            wait_go(1);
            step(2);
            store_start = 1'b1;
            step(1);
            store_start = 1'b0;
        end
        k = 0;
        while (n_done < 1 && k < 3000) begin
            step(1); k++;
        end
        step(6);
        check({tag, ".done_cnt"}, 128'(n_done), 128'd1);
        check({tag, ".go_latency"}, 128'(first_go_cyc - start_cyc), 128'd2);
        check({tag, ".done_latency"}, 128'(done_cyc - last_exit_cyc), 128'd2);
        check({tag, ".tx_cnt"}, 128'(n_go), 128'(v.n_tx));
        for (int i = 0; i < v.n_tx; i++) begin
            check($sformatf("%s.addr%0d", tag, i), 128'(go_base[i]), 128'(v.addr[i]));
            check($sformatf("%s.len%0d", tag, i), 128'(go_len[i]), 128'(TC * 4));
            check($sformatf("%s.beats%0d", tag, i), 128'(beats_tx[i]), 128'(BEATS));
        end
        check({tag, ".pops"}, 128'(n_pop), 128'(v.n_pops));
        check({tag, ".pushes"}, 128'(n_push), 128'(v.n_beats));
        check({tag, ".beat_q"}, 128'(beats_q.size()), 128'(v.n_beats));
        for (int b = 0; b < v.n_beats && b < beats_q.size(); b++) begin
            for (int w = 0; w < WCNT; w++) e[32*w +: 32] = 32'(WCNT * b + w);
            check($sformatf("%s.beat%0d", tag, b), beats_q[b], e);
        end
        check({tag, ".unstable"}, 128'(viol_unstable), 128'd0);
        check({tag, ".push_full"}, 128'(viol_full_push), 128'd0);
        check({tag, ".pop_empty"}, 128'(viol_pop_empty), 128'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'd0, 32'h1000, 4, {32'h10A0, 32'h1080, 32'h1020, 32'h1000}, 32, 8, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'd3, 32'h1000, 2, {32'h0, 32'h0, 32'h10E0, 32'h1060}, 16, 4, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{16'd0, 32'h1000, 4, {32'h10A0, 32'h1080, 32'h1020, 32'h1000}, 32, 8, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{16'd0, 32'h1000, 4, {32'h10A0, 32'h1080, 32'h1020, 32'h1000}, 32, 8, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'd0, 32'h1000, 4, {32'h10A0, 32'h1080, 32'h1020, 32'h1000}, 32, 8, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{16'd2, 32'hFFFF_FFF0, 4, {32'hD0, 32'hB0, 32'h50, 32'h30}, 32, 8, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; store_start = 1'b0; full = 1'b0; stall_en = 1'b0;
        store_base_addr = '0; tile_base_m = '0; tile_base_row = '0; tile_base_col = '0;
        step(2);
        @(negedge clk);
        check("rst.pop", 128'(bus.store_fifo_pop), 128'd0);
        check("rst.go", 128'(bus.wmst_go), 128'd0);
        check("rst.push", 128'(bus.wmst_user_write_buffer), 128'd0);
        check("rst.data", bus.wmst_user_buffer_data, 128'd0);
        check("rst.base", 128'(bus.wmst_write_base), 128'd0);
        check("rst.len", 128'(bus.wmst_write_length), 128'd0);
        check("rst.fixed", 128'(bus.wmst_fixed_location), 128'd0);
        check("rst.done", 128'(store_done), 128'd0);
        step(1);
        rst = 1'b0;
        step(1);

        for (int i = 0; i < 6; i++) run_case(vecs[i], 1'b1, $sformatf("vec%0d", i));

        // Reset in the middle of the second row's fill abandons the tile.
        do_reset();
        store_base_addr = 32'h1000; tile_base_m = '0; tile_base_row = '0; tile_base_col = '0;
        store_start = 1'b1;
        step(1);
        store_start = 1'b0;
        wait_go(2);
        step(2);
        rst = 1'b1;
        step(1);
        check("midrst.pop", 128'(bus.store_fifo_pop), 128'd0);
        check("midrst.go", 128'(bus.wmst_go), 128'd0);
        check("midrst.push", 128'(bus.wmst_user_write_buffer), 128'd0);
        check("midrst.data", bus.wmst_user_buffer_data, 128'd0);
        check("midrst.done", 128'(store_done), 128'd0);
        rst = 1'b0;
        step(20);
        check("midrst.quiet_go", 128'(n_go), 128'd0);
        check("midrst.quiet_pop", 128'(n_pop), 128'd0);
        check("midrst.quiet_push", 128'(n_push), 128'd0);
        check("midrst.quiet_done", 128'(n_done), 128'd0);
        run_case(vecs[0], 1'b0, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/out_fm_fifo_to_wmst_tile.md
# out_fm_fifo_to_wmst_tile

Store-side tile adapter for the convolution accelerator. It drains one output-feature-map tile from the out-FM FIFO, 32 bits per pop, and packs the words into XDW-bit beats. It issues one Avalon write-master transaction per tile row to the row's address in the M×R×C output feature map in external memory. It sits between the compute array's output FIFO and the write master, and is the store-direction counterpart of the input-FM load path.

## Interface
- AW, 12: internal counter width
- CW, 16: tile coordinate / length width
- DW, 32: FIFO word width
- XAW, 32: external byte-address width
- XDW, 128: write-master data width
- M, 32 / R, 64 / C, 32: output FM channels, rows, cols
- Tm, 16 / Tr, 64 / Tc, 16: tile channels, rows, cols (Tc multiple of WCNT; C multiple of Tc)
- WCNT, XDW/DW: words per beat

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- store_start  in  1  one-cycle start pulse; ignored unless IDLE
- store_done  out  1  one-cycle pulse when tile fully written
- store_base_addr  in  XAW  byte address of output FM element (0,0,0)
- tile_base_m / tile_base_row / tile_base_col  in  CW  tile origin, sampled on accepted store_start
- store_fifo_pop  out  1  FIFO read request
- store_fifo_data  in  DW  FIFO data, valid the cycle after pop
- store_fifo_empty  in  1  FIFO empty
- wmst_fixed_location  out  1  constant 0
- wmst_write_base  out  XAW  row byte address
- wmst_write_length  out  CW  row length in bytes = Tc*4
- wmst_go  out  1  one-cycle transaction start
- wmst_done  in  1  write master idle
- wmst_user_write_buffer  out  1  one-cycle beat push
- wmst_user_buffer_data  out  XDW  packed beat, word i at [32i+31:32i]
- wmst_user_buffer_full  in  1  master buffer full; no push while high

## Operation
- Effective extent: rows_v = min(Tr, R−tile_base_row); ch_v = min(Tm, M−tile_base_m). The FIFO delivers exactly ch_v×rows_v×Tc words, channel-major, then row, then col.
- FSM states:
  - IDLE: on store_start, latch origin and go to ADDR.
  - ADDR: row_addr = store_base_addr + (((tile_base_m)*R + tile_base_row)*C + tile_base_col)*4, mod 2^XAW; ch_addr = row_addr. Go to GO.
  - GO: wait for wmst_done=1, then assert wmst_go for 1 cycle with write_base=row_addr and length=Tc*4. Go to FILL.
  - FILL: pop and pack; after Tc/WCNT beats are pushed, go to WAIT_DONE.
  - WAIT_DONE: exit once wmst_done=0 has been seen since go and wmst_done=1 is now sampled.
  - NEXT: r+1<rows_v → r++, row_addr+=C*4, go to GO. Else c+1<ch_v → c++, r=0, ch_addr+=R*C*4, row_addr=ch_addr, go to GO. Else go to DONE.
  - DONE: store_done=1 for 1 cycle, then IDLE.
- Pop rule (FILL only): store_fifo_pop = !empty && row_pops<Tc && (pack_cnt + pop_inflight) < WCNT. Data is captured into slot pack_cnt on the cycle after the pop.
- Beat rule: when pack_cnt==WCNT and !wmst_user_buffer_full, assert wmst_user_write_buffer for 1 cycle with the packed data; pack_cnt clears. With full high, the beat is held and popping stalls.
- store_start in any non-IDLE state: ignored.

## Timing
- Reset: all outputs 0, FSM IDLE, counters, pack register and in-flight flag cleared. Reset mid-tile abandons the tile: no further go, pop or push from the next cycle, and no store_done.
- store_start at cycle t → ADDR at t+1 → earliest wmst_go at t+2 if wmst_done=1.
- wmst_write_base and wmst_write_length are stable from the go cycle through WAIT_DONE.
- Unstalled throughput ≥ WCNT words per WCNT+2 cycles.
- Empty FIFO mid-row: popping pauses, and no partial beat is ever pushed.
- store_done is asserted 2 cycles after the final WAIT_DONE exit (NEXT, then DONE).

## Test plan
- Params M=2,R=4,C=8,Tm=2,Tr=2,Tc=8,WCNT=4, base 0x1000, origin (0,0,0), FIFO words 0..31 → 4 transactions at 0x1000, 0x1020, 0x1080, 0x10A0; 2 beats each; first beat {3,2,1,0}; single store_done.
- Same params, origin row=3 → rows_v=1, 2 transactions at 0x1060, 0x10E0; exactly 16 pops.
- wmst_user_buffer_full held high for 10 cycles after the first beat is ready → beat data and push held, no pops, no data loss; correct order after release.
- FIFO empty for 5 cycles after the 3rd word → no push until 4 words are packed; beat = words 3..0.
- rst asserted during the second row's FILL → all outputs 0 next cycle; a new store_start then completes a full tile correctly.
- store_start re-pulsed during FILL → ignored; transaction count and addresses unchanged.
